wb_stage: RTL and testbench

- Write-back stage directly downstream of the EX/WB pipeline register.
- Consumes the registered ALU result, RAM address, destination register and control bits.
- ALU results: writes the register file one cycle later.
- Loads: runs a level-handshake read to data RAM, stalls the upstream pipeline until data returns or a timeout fires, then writes the loaded word.
- Single clock domain; one outstanding load at most.

---
 rtl/wb_stage_pkg.sv | 12 +
 rtl/wb_stage.sv | 123 ++++++++++++
 tb/tb_wb_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared state encoding for the write-back stage
package wb_stage_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT
    } wb_state_e;

endpackage

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage: ALU writes in one cycle, loads via a
// level-handshake RAM read with upstream stall and timeout
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     alu_output_in,
    input  logic [ADDR_WIDTH-1:0]     ram_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr_wr_in,
    input  logic                      wr_reg_in,
    input  logic                      mem_to_reg_in,
    output logic                      ram_rd_req,
    output logic [ADDR_WIDTH-1:0]     ram_rd_addr,
    input  logic                      ram_rd_valid,
    input  logic [DATA_WIDTH-1:0]     ram_rd_data,
    output logic                      rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0]     rf_wr_data,
    output logic                      stall,
    output logic                      mem_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    wb_state_e                 r_state;
    wb_state_e                 w_state_n;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_n;
    logic [REG_ADDR_WIDTH-1:0] r_ld_reg;
    logic [REG_ADDR_WIDTH-1:0] w_ld_reg_n;
    logic                      w_req_n;
    logic [ADDR_WIDTH-1:0]     w_rd_addr_n;
    logic                      w_wr_en_n;
    logic [REG_ADDR_WIDTH-1:0] w_wr_addr_n;
    logic [DATA_WIDTH-1:0]     w_wr_data_n;
    logic                      w_err_n;

    logic w_alu_wr;
    logic w_load;

    assign w_alu_wr = wr_reg_in & ~mem_to_reg_in;
    assign w_load   = wr_reg_in & mem_to_reg_in;

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_ld_reg_n  = r_ld_reg;
        w_req_n     = ram_rd_req;
        w_rd_addr_n = ram_rd_addr;
        w_wr_en_n   = 1'b0;
        w_wr_addr_n = rf_wr_addr;
        w_wr_data_n = rf_wr_data;
        w_err_n     = 1'b0;
        stall       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    stall       = 1'b1;
                    w_state_n   = S_WAIT;
                    w_cnt_n     = '0;
                    w_req_n     = 1'b1;
                    w_rd_addr_n = ram_addr_in;
                    w_ld_reg_n  = reg_addr_wr_in;
                end else if (w_alu_wr) begin
                    // r0 is hardwired zero, so the strobe is suppressed for it
                    w_wr_en_n   = (reg_addr_wr_in != '0);
                    w_wr_addr_n = reg_addr_wr_in;
                    w_wr_data_n = alu_output_in;
                end
            end
            S_WAIT: begin
                // valid in the last counted cycle still completes the load
                if (ram_rd_valid) begin
                    w_wr_en_n   = (r_ld_reg != '0);
                    w_wr_addr_n = r_ld_reg;
                    w_wr_data_n = ram_rd_data;
                    w_req_n     = 1'b0;
                    w_state_n   = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_n     = 1'b1;
                    w_req_n     = 1'b0;
                    w_state_n   = S_IDLE;
                end else begin
                    stall       = 1'b1;
                    w_cnt_n     = r_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ld_reg    <= '0;
            ram_rd_req  <= 1'b0;
            ram_rd_addr <= '0;
            rf_wr_en    <= 1'b0;
            rf_wr_addr  <= '0;
            rf_wr_data  <= '0;
            mem_err     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_ld_reg    <= w_ld_reg_n;
            ram_rd_req  <= w_req_n;
            ram_rd_addr <= w_rd_addr_n;
            rf_wr_en    <= w_wr_en_n;
            rf_wr_addr  <= w_wr_addr_n;
            rf_wr_data  <= w_wr_data_n;
            mem_err     <= w_err_n;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed table-driven bench for wb_stage
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic [31:0] alu_output_in;
    logic [7:0]  ram_addr_in;
    logic [4:0]  reg_addr_wr_in;
    logic        wr_reg_in;
    logic        mem_to_reg_in;
    logic        ram_rd_req;
    logic [7:0]  ram_rd_addr;
    logic        ram_rd_valid;
    logic [31:0] ram_rd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        stall;
    logic        mem_err;

    int n_pass;
    int n_total;

    wb_stage #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .REG_ADDR_WIDTH(5), .MEM_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_output_in(alu_output_in), .ram_addr_in(ram_addr_in),
        .reg_addr_wr_in(reg_addr_wr_in), .wr_reg_in(wr_reg_in),
        .mem_to_reg_in(mem_to_reg_in),
        .ram_rd_req(ram_rd_req), .ram_rd_addr(ram_rd_addr),
        .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .stall(stall), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [7:0]  addr;
        logic        vld;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic [7:0]  e_raddr;
        logic        e_en;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic wr, logic m2r, logic [4:0] rd, logic [31:0] alu,
                                logic [7:0] addr, logic vld, logic [31:0] rdata,
                                logic e_stall, logic e_req, logic [7:0] e_raddr,
                                logic e_en, logic [4:0] e_waddr, logic [31:0] e_wdata);
        vec_t v;
        v.wr = wr; v.m2r = m2r; v.rd = rd; v.alu = alu; v.addr = addr;
        v.vld = vld; v.rdata = rdata; v.e_stall = e_stall; v.e_req = e_req;
        v.e_raddr = e_raddr; v.e_en = e_en; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic wr, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [7:0] addr,
                         input logic vld, input logic [31:0] rdata);
        wr_reg_in = wr; mem_to_reg_in = m2r; reg_addr_wr_in = rd;
        alu_output_in = alu; ram_addr_in = addr; ram_rd_valid = vld; ram_rd_data = rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_run(input bit with_valid);
        next_cycle();
        drive(1, 1, 5'd12, 0, 8'h44, 0, 0);
        for (int c = 0; c <= 9; c++) begin
            if (c == 1) drive(0, 0, 0, 0, 0, 0, 0);
            if (c == 8 && with_valid) drive(0, 0, 0, 0, 0, 1, 32'hA5A5);
            if (c == 9) drive(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("to%0d_stall_c%0d", with_valid, c), stall, (c < 8) ? 1 : 0);
            chk($sformatf("to%0d_req_c%0d", with_valid, c), ram_rd_req, (c >= 1 && c <= 8) ? 1 : 0);
            if (c == 9) begin
                chk($sformatf("to%0d_err", with_valid), mem_err, with_valid ? 0 : 1);
                chk($sformatf("to%0d_en", with_valid), rf_wr_en, with_valid ? 1 : 0);
                if (with_valid) begin
                    chk("to1_waddr", rf_wr_addr, 12);
                    chk("to1_wdata", rf_wr_data, 32'hA5A5);
                end
            end else begin
                chk($sformatf("to%0d_err_c%0d", with_valid, c), mem_err, 0);
            end
            if (c < 9) next_cycle();
        end
        next_cycle();
        @(negedge clk);
        chk($sformatf("to%0d_err_pulse", with_valid), mem_err, 0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_req", ram_rd_req, 0);
        chk("rst_raddr", ram_rd_addr, 0);
        chk("rst_en", rf_wr_en, 0);
        chk("rst_waddr", rf_wr_addr, 0);
        chk("rst_wdata", rf_wr_data, 0);
        chk("rst_err", mem_err, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        reset = 1'b1;

        //               wr m2r rd  alu       addr   v  rdata      stall req raddr  en waddr wdata
        vecs[0]  = mk(0, 0, 0, 0,         0,     0, 0,         0, 0, 0,     0, 0, 0);
        vecs[1]  = mk(1, 0, 5, 32'h1234,  0,     0, 0,         0, 0, 0,     0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0,         0,     0, 0,         0, 0, 0,     1, 5, 32'h1234);
        vecs[3]  = mk(1, 0, 0, 32'hFFFF,  0,     0, 0,         0, 0, 0,     0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,         0,     0, 0,         0, 0, 0,     0, 0, 0);
        vecs[5]  = mk(0, 1, 9, 0,         8'h55, 0, 0,         0, 0, 0,     0, 0, 0);
        vecs[6]  = mk(1, 1, 7, 0,         8'h10, 0, 0,         1, 0, 0,     0, 0, 0);
        vecs[7]  = mk(1, 1, 7, 0,         8'h10, 0, 0,         1, 1, 8'h10, 0, 0, 0);
        vecs[8]  = mk(1, 1, 7, 0,         8'h10, 0, 0,         1, 1, 8'h10, 0, 0, 0);
        vecs[9]  = mk(1, 1, 7, 0,         8'h10, 1, 32'hCAFE,  0, 1, 8'h10, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0,         0,     0, 0,         0, 0, 0,     1, 7, 32'hCAFE);
        vecs[11] = mk(1, 1, 9, 0,         8'h20, 0, 0,         1, 0, 0,     0, 0, 0);
        vecs[12] = mk(1, 1, 9, 0,         8'h20, 1, 32'hBEEF,  0, 1, 8'h20, 0, 0, 0);
        vecs[13] = mk(1, 0, 3, 9,         0,     0, 0,         0, 0, 0,     1, 9, 32'hBEEF);
        vecs[14] = mk(0, 0, 0, 0,         0,     0, 0,         0, 0, 0,     1, 3, 9);
        vecs[15] = mk(0, 0, 0, 0,         0,     1, 32'h7777,  0, 0, 0,     0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0,         0,     0, 0,         0, 0, 0,     0, 0, 0);
        vecs[17] = mk(1, 1, 0, 0,         8'h30, 0, 0,         1, 0, 0,     0, 0, 0);
        vecs[18] = mk(1, 1, 0, 0,         8'h30, 1, 32'h55,    0, 1, 8'h30, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0,         0,     0, 0,         0, 0, 0,     0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            next_cycle();
            drive(vecs[i].wr, vecs[i].m2r, vecs[i].rd, vecs[i].alu,
                  vecs[i].addr, vecs[i].vld, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("v%0d_req", i), ram_rd_req, vecs[i].e_req);
            chk($sformatf("v%0d_en", i), rf_wr_en, vecs[i].e_en);
            chk($sformatf("v%0d_err", i), mem_err, 0);
            if (vecs[i].e_req) chk($sformatf("v%0d_raddr", i), ram_rd_addr, vecs[i].e_raddr);
            if (vecs[i].e_en) begin
                chk($sformatf("v%0d_waddr", i), rf_wr_addr, vecs[i].e_waddr);
                chk($sformatf("v%0d_wdata", i), rf_wr_data, vecs[i].e_wdata);
            end
        end

        timeout_run(0);
        timeout_run(1);

        // async reset in the second WAIT cycle, away from any clock edge
        next_cycle();
        drive(1, 1, 5'd6, 0, 8'h66, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        chk("ar_pre_req", ram_rd_req, 1);
        chk("ar_pre_stall", stall, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_req", ram_rd_req, 0);
        chk("ar_stall", stall, 0);
        chk("ar_raddr", ram_rd_addr, 0);
        chk("ar_en", rf_wr_en, 0);
        chk("ar_waddr", rf_wr_addr, 0);
        chk("ar_wdata", rf_wr_data, 0);
        chk("ar_err", mem_err, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("ar_idle_en_c%0d", c), rf_wr_en, 0);
            chk($sformatf("ar_idle_req_c%0d", c), ram_rd_req, 0);
        end
        next_cycle();
        drive(1, 0, 5'd4, 32'h77, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ar_alu_en", rf_wr_en, 1);
        chk("ar_alu_waddr", rf_wr_addr, 4);
        chk("ar_alu_wdata", rf_wr_data, 32'h77);
        next_cycle();
        @(negedge clk);
        chk("ar_alu_pulse", rf_wr_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
